// File: rtl/ysyx_22041461_mdu.sv
// Iterative RV64M multiply/divide unit. It takes one operation at a time
// through a valid/ready handshake and returns the 64-bit result through a
// second valid/ready handshake.
// The multiplier is a radix-2 shift-add and the divider is a restoring divider.
// Both work on magnitudes. The sign is applied on the last iteration.
module ysyx_22041461_mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    state_t        state_reg, state_next;
    logic [6:0]    cnt_reg;
    logic [127:0]  prod_reg;      // {partial product, remaining multiplier}
    logic [63:0]   opb_reg;       // multiplicand (mul) or divisor (div)
    logic [63:0]   rem_reg, quo_reg, result_reg;
    logic          neg_reg, nrem_reg, hi_reg, sel_rem_reg, w_reg;

    logic dec_mul, dec_w, dec_s1, dec_s2, dec_hi, dec_rem, dec_legal;
    logic [63:0] ext_a, ext_b, mag_a, mag_b, spec_raw, spec_res;
    logic a_neg, b_neg, div_zero, div_ovf, dec_special, accept;

    logic [64:0]  mul_sum, div_shift;
    logic [127:0] prod_nx, p_eff, p_fin;
    logic [63:0]  rem_nx, quo_nx, div_diff, mul_res, q_fin, r_fin, raw_res, fin_res;
    logic         div_ge;

    assign in_ready  = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign result    = result_reg;
    assign accept    = in_valid & in_ready & ~flush;

    // Opcode decode: operation class, operand signedness, result selection.
    // MUL and MULW only use the low half of the product. Those bits are the same
    // for signed and unsigned operands, so both are treated as unsigned.
    always_comb begin
        dec_mul = 1'b0; dec_w = 1'b0; dec_s1 = 1'b0; dec_s2 = 1'b0;
        dec_hi = 1'b0; dec_rem = 1'b0; dec_legal = 1'b1;
        case (op)
            4'd0:  dec_mul = 1'b1;
            4'd1:  begin dec_mul = 1'b1; dec_hi = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
            4'd2:  begin dec_mul = 1'b1; dec_hi = 1'b1; dec_s1 = 1'b1; end
            4'd3:  begin dec_mul = 1'b1; dec_hi = 1'b1; end
            4'd4:  begin dec_s1 = 1'b1; dec_s2 = 1'b1; end
            4'd5:  ;
            4'd6:  begin dec_s1 = 1'b1; dec_s2 = 1'b1; dec_rem = 1'b1; end
            4'd7:  dec_rem = 1'b1;
            4'd8:  begin dec_mul = 1'b1; dec_w = 1'b1; end
            4'd9:  begin dec_w = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
            4'd10: dec_w = 1'b1;
            4'd11: begin dec_w = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; dec_rem = 1'b1; end
            4'd12: begin dec_w = 1'b1; dec_rem = 1'b1; end
            default: dec_legal = 1'b0;
        endcase
    end

    // Operand extension and magnitudes. Divide-by-zero and signed overflow are resolved here.
    always_comb begin
        ext_a = dec_w ? (dec_s1 ? {{32{src1[31]}}, src1[31:0]} : {32'd0, src1[31:0]}) : src1;
        ext_b = dec_w ? (dec_s2 ? {{32{src2[31]}}, src2[31:0]} : {32'd0, src2[31:0]}) : src2;
        a_neg = dec_s1 & ext_a[63];
        b_neg = dec_s2 & ext_b[63];
        mag_a = a_neg ? (64'd0 - ext_a) : ext_a;
        mag_b = b_neg ? (64'd0 - ext_b) : ext_b;
        div_zero = (ext_b == 64'd0);
        div_ovf  = dec_s1 & dec_s2 & (&ext_b) &
                   (ext_a == (dec_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        dec_special = dec_legal & ~dec_mul & (div_zero | div_ovf);
        if (div_zero)
            spec_raw = dec_rem ? ext_a : 64'hFFFF_FFFF_FFFF_FFFF;
        else
            spec_raw = dec_rem ? 64'd0 : ext_a;
        spec_res = dec_w ? {{32{spec_raw[31]}}, spec_raw[31:0]} : spec_raw;
    end

    // One iteration of each datapath, and the signed final result built from the iterated values.
    // After 32 iterations a W product sits 32 bits higher in prod, so it is shifted back down.
    always_comb begin
        mul_sum   = {1'b0, prod_reg[127:64]} + (prod_reg[0] ? {1'b0, opb_reg} : 65'd0);
        prod_nx   = {mul_sum, prod_reg[63:1]};
        div_shift = {rem_reg, quo_reg[63]};
        div_ge    = (div_shift >= {1'b0, opb_reg});
        div_diff  = div_shift[63:0] - opb_reg;
        rem_nx    = div_ge ? div_diff : div_shift[63:0];
        quo_nx    = {quo_reg[62:0], div_ge};
        p_eff     = w_reg ? {32'd0, prod_nx[127:32]} : prod_nx;
        p_fin     = neg_reg ? (128'd0 - p_eff) : p_eff;
        mul_res   = hi_reg ? p_fin[127:64] : p_fin[63:0];
        q_fin     = neg_reg ? (64'd0 - quo_nx) : quo_nx;
        r_fin     = nrem_reg ? (64'd0 - rem_nx) : rem_nx;
        raw_res   = (state_reg == ST_MUL) ? mul_res : (sel_rem_reg ? r_fin : q_fin);
        fin_res   = w_reg ? {{32{raw_res[31]}}, raw_res[31:0]} : raw_res;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic. Flush overrides every transition.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (in_valid) begin
                    if (!dec_legal || dec_special) state_next = ST_DONE;
                    else if (dec_mul)              state_next = ST_MUL;
                    else                           state_next = ST_DIV;
                end
                ST_MUL, ST_DIV: if (cnt_reg == 7'd1) state_next = ST_DONE;
                ST_DONE: if (out_ready) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath. Operands are loaded on accept, then one bit is processed per cycle.
    // The result is written only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0; prod_reg <= '0; opb_reg <= '0; rem_reg <= '0; quo_reg <= '0;
            result_reg <= '0; neg_reg <= 1'b0; nrem_reg <= 1'b0; hi_reg <= 1'b0;
            sel_rem_reg <= 1'b0; w_reg <= 1'b0;
        end else if (accept) begin
            cnt_reg     <= dec_w ? 7'd32 : 7'd64;
            prod_reg    <= {64'd0, mag_b};
            opb_reg     <= dec_mul ? mag_a : mag_b;
            rem_reg     <= '0;
            quo_reg     <= dec_w ? {mag_a[31:0], 32'd0} : mag_a;
            neg_reg     <= a_neg ^ b_neg;
            nrem_reg    <= a_neg;
            hi_reg      <= dec_hi;
            sel_rem_reg <= dec_rem;
            w_reg       <= dec_w;
            if (!dec_legal)       result_reg <= '0;
            else if (dec_special) result_reg <= spec_res;
        end else if (!flush && (state_reg == ST_MUL || state_reg == ST_DIV)) begin
            cnt_reg <= cnt_reg - 7'd1;
            if (state_reg == ST_MUL) begin
                prod_reg <= prod_nx;
            end else begin
                rem_reg <= rem_nx;
                quo_reg <= quo_nx;
            end
            if (cnt_reg == 7'd1) result_reg <= fin_res;
        end
    end
endmodule

// File: tb/tb_ysyx_22041461_mdu.sv
// Scoreboard bench for the iterative multiply/divide unit. The driver pushes
// the reference result and the expected latency at each accept. A separate
// monitor compares them whenever the unit presents a result.
module tb_ysyx_22041461_mdu;
    logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [3:0]  op;
    logic [63:0] src1, src2, result;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic first_seen = 1'b0;
    logic bp_random = 1'b0;
    logic forced_ready = 1'b1;
    logic rnd_ready = 1'b1;

    assign out_ready = bp_random ? rnd_ready : forced_ready;

    ysyx_22041461_mdu dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src1(src1), .src2(src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: the architectural RV64M results, computed with plain arithmetic.
    function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        longint       sa, sb;
        int           wa, wb;
        logic [31:0]  ua, ub, r32;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        r32 = 32'd0;
        case (o)
            4'd0: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
            4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
            4'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            4'd4: begin
                if (b == 64'd0) return 64'hFFFF_FFFF_FFFF_FFFF;
                if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return a;
                return sa / sb;
            end
            4'd5: return (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            4'd6: begin
                if (b == 64'd0) return a;
                if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 64'd0;
                return sa % sb;
            end
            4'd7: return (b == 64'd0) ? a : a % b;
            4'd8: r32 = ua * ub;
            4'd9: begin
                if (ub == 32'd0) r32 = 32'hFFFF_FFFF;
                else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = ua;
                else r32 = wa / wb;
            end
            4'd10: r32 = (ub == 32'd0) ? 32'hFFFF_FFFF : ua / ub;
            4'd11: begin
                if (ub == 32'd0) r32 = ua;
                else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = 32'd0;
                else r32 = wa % wb;
            end
            4'd12: r32 = (ub == 32'd0) ? ua : ua % ub;
            default: return 64'd0;
        endcase
        return {{32{r32[31]}}, r32};
    endfunction

    // Latency in cycles: 1 for the special cases, 33 for W ops, 65 for the full-width ops.
    function automatic int exp_lat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        if (o >= 4'd13) return 1;
        if (o >= 4'd4 && o <= 4'd7) begin
            if (b == 64'd0) return 1;
            if ((o == 4'd4 || o == 4'd6) && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
            return 65;
        end
        if (o >= 4'd9 && o <= 4'd12) begin
            if (b[31:0] == 32'd0) return 1;
            if ((o == 4'd9 || o == 4'd11) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        if (o == 4'd8) return 33;
        return 65;
    endfunction

    function automatic logic [63:0] rnd_opnd();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = 64'd1;
            2: v = 64'hFFFF_FFFF_FFFF_FFFF;
            3: v = 64'h8000_0000_0000_0000;
            4: v = {v[63:32], 32'h8000_0000};
            5: v = v >> $urandom_range(1, 62);
            default: ;
        endcase
        return v;
    endfunction

    // Called one time unit after a rising edge. It returns one time unit after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        int   n;
        n = 0;
        op = o; src1 = a; src2 = b; in_valid = 1'b1;
        while (!in_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.op = o; e.a = a; e.b = b;
        e.res = ref_res(o, a, b);
        e.acc = cyc;
        e.lat = exp_lat(o, a, b);
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: checks each presented result against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out_valid actual=%h required=no_output", result);
            end else begin
                mon_e = exp_q[0];
                if (!first_seen) begin
                    first_seen = 1'b1;
                    chk("latency", 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
                    chk("done_in_ready", 64'(in_ready), 64'd0);
                    chk("done_busy", 64'(busy), 64'd1);
                end
                chk("result", result, mon_e.res);
                if (out_ready) begin
                    $display("txn op=%0d a=%h b=%h result=%h expected=%h", mon_e.op, mon_e.a, mon_e.b, result, mon_e.res);
                    void'(exp_q.pop_front());
                    first_seen = 1'b0;
                end
            end
        end else begin
            first_seen = 1'b0;
        end
    end

    logic [3:0]  d_op [16] = '{4'd0, 4'd3, 4'd1, 4'd2, 4'd4, 4'd6, 4'd10, 4'd5,
                               4'd7, 4'd4, 4'd6, 4'd9, 4'd11, 4'd14, 4'd8, 4'd12};
    logic [63:0] d_a  [16] = '{64'd3, '1, '1, '1, -64'sd7, -64'sd7, 64'h8000_0000, 64'd5,
                               64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                               64'h8000_0000, 64'd5, 64'd1, 64'h7FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF7};
    logic [63:0] d_b  [16] = '{64'hFFFF_FFFF_FFFF_FFFB, '1, '1, 64'd2, 64'd2, 64'd2, 64'd1, 64'd0,
                               64'd0, '1, '1, 64'hFFFF_FFFF, 64'd0, 64'd2, 64'hFFFF_FFFF, 64'd4};

    initial begin
        int n;
        logic [63:0] bp_exp;
        rst_n = 1'b0; in_valid = 1'b0; op = 4'd0; src1 = '0; src2 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", result, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed operations: worked examples and boundary cases.
        for (int i = 0; i < 16; i++) issue(d_op[i], d_a[i], d_b[i]);
        drain();

        // Backpressure: the unit holds DONE while out_ready is low.
        forced_ready = 1'b0;
        issue(4'd0, 64'd7, 64'd9);
        bp_exp = ref_res(4'd0, 64'd7, 64'd9);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_reached_done", 64'(out_valid), 64'd1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_result", result, bp_exp);
        end
        @(posedge clk); #1;
        forced_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_busy", 64'(busy), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);

        // A flush in the same cycle as an offered op wins over the accept.
        op = 4'd0; src1 = 64'd2; src2 = 64'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_vs_accept_busy", 64'(busy), 64'd0);

        // A flush in the middle of a divide discards it. A MUL offered right after must complete.
        issue(4'd4, 64'd1000000007, 64'd3);
        repeat (20) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        issue(4'd1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1234_5678_9ABC_DEF0);
        drain();

        // Reset in the middle of a multiply returns every output to its reset value at once.
        issue(4'd0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_result", result, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Random operations with random output backpressure.
        bp_random = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  ro;
            logic [63:0] ra, rb;
            ro = 4'($urandom_range(0, 15));
            ra = rnd_opnd();
            rb = rnd_opnd();
            issue(ro, ra, rb);
        end
        drain();
        bp_random = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_22041461_mdu.md
# ysyx_22041461_mdu

Iterative RV64M multiply/divide unit with its own sequencer, attached beside the EXE stage. EXE hands over one M-extension operation through a valid/ready handshake and stalls on `busy`. The unit returns the 64-bit result through a second valid/ready handshake. One operation is in flight at a time. It is flushable on branch redirect or trap.

## Interface
Parameters:
- none (operand width fixed at 64)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous reset, active-low
- `in_valid`  in  1  EXE presents an operation
- `in_ready`  out  1  unit can accept; high only in IDLE
- `op`  in  4  operation code; values listed under Operation
- `src1`  in  64  rs1 value (dividend / multiplicand)
- `src2`  in  64  rs2 value (divisor / multiplier)
- `flush`  in  1  synchronous cancel of any in-flight or pending result
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes result
- `result`  out  64  final result
- `busy`  out  1  state != IDLE; EXE stall request

## Operation
- Op codes:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
  - 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW
  - 13–15 illegal
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE → MUL or DIV on accept (`in_valid & in_ready & !flush`). Operands are latched as magnitudes; the result sign is recorded.
- MUL: radix-2 shift-add, one bit per cycle, 128-bit product register.
- DIV: restoring, one quotient bit per cycle, 64-bit remainder register.
- Iteration count is 64 for full-width ops and 32 for W ops. A down-counter is loaded on accept; the FSM moves to DONE when the counter reaches 0.
- Sign handling:
  - Signed inputs are converted to magnitudes; the final result is negated if its recorded sign is negative.
  - MULHSU treats only src1 as signed.
  - REM result takes the sign of the dividend.
- W ops:
  - Operands are the low 32 bits, sign- or zero-extended per op.
  - The result is the low 32 bits, sign-extended to 64. This applies to DIVUW/REMUW too.
- Selection: MUL/MULW return the low product half; MULH* return the high half.
- Special cases resolve at accept and go straight to DONE without iterating:
  - Divide by zero: quotient = all ones (0xFFFF_FFFF_FFFF_FFFF), remainder = dividend.
  - Signed overflow (most-negative / −1, at 64 or 32 bits): quotient = dividend, remainder = 0.
  - Illegal op: result = 0.
- DONE: `out_valid` = 1 and `result` is held stable until `out_valid & out_ready`, then the FSM returns to IDLE.
- Flush:
  - From any state, the FSM returns to IDLE at the next edge and `out_valid` drops.
  - Partial state is discarded.
  - Flush has priority over a same-cycle accept and over a same-cycle output handshake; the output is dropped.

## Timing
- Reset values: state IDLE; `in_ready` = 1, `out_valid` = 0, `result` = 0, `busy` = 0. All counters and registers are cleared.
- Reset asserted mid-operation aborts the operation immediately (asynchronously). No result is produced.
- Latency is measured from the accepting edge to the first cycle `out_valid` is high:
  - full-width mul/div: 65 cycles
  - W ops: 33 cycles
  - special cases / illegal op: 1 cycle
- `in_ready` is combinational from state; no accept in DONE, including in the output-handshake cycle. Peak throughput is one op per (latency + 1) cycles.
- `busy` is high from the cycle after accept through the DONE cycle of the output handshake.
- `result` changes only on the edge entering DONE.
- `out_valid` never toggles while `out_ready` is low, except on flush or reset.

## Test plan
- MUL src1 = 3, src2 = 0xFFFF_FFFF_FFFF_FFFB → `result` = 0xFFFF_FFFF_FFFF_FFF1, `out_valid` exactly 65 cycles after accept.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF → `result` = 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → `result` = 0.
- DIV −7 / 2 → 0xFFFF_FFFF_FFFF_FFFD. REM −7 / 2 → 0xFFFF_FFFF_FFFF_FFFF. DIVUW src1 = 0x8000_0000, src2 = 1 → 0xFFFF_FFFF_8000_0000 after 33 cycles.
- DIVU 5 / 0 → all ones; REMU 5 / 0 → 5; DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000; REM of the same → 0. Each completes 1 cycle after accept.
- Backpressure: `out_ready` held low 10 cycles in DONE → `result`/`out_valid` stable, `in_ready` = 0 throughout. Releasing `out_ready` → IDLE next edge.
- Flush at iteration 20 of a DIV → `busy` = 0 next cycle, no `out_valid` ever. A MUL offered the following cycle is accepted and correct. `rst_n` pulsed low mid-MUL → all outputs at reset values immediately.
